// File: rtl/ext_mem_bus_initiator.sv
// ext_mem_bus_initiator
// Initiator side of the peripheral memory bus. Turns one CPU load/store into
// an address phase (REQ) and a data phase (DATA), then reports completion with
// a one-cycle cpu_ack (RESP). Load data is sign/zero-extended by access size.
// Optional build macro: EXT_BUS_TIMEOUT_EN adds a bus wait counter that aborts
// a transaction with cpu_err after TIMEOUT_CYCLES stalled cycles.
module ext_mem_bus_initiator #(
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_unsigned,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_busy,
  output logic              cpu_ack,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_err,
  output logic              bus_req,
  output logic              bus_wr_en,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [1:0]        bus_size,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  state_t              r_state;
  logic                r_we;
  logic                r_unsigned;
  logic [1:0]          r_size;
  logic                r_busy;
  logic                r_cpu_ack;
  logic [31:0]         r_cpu_rdata;
  logic                r_cpu_err;
  logic                r_bus_req;
  logic                r_bus_wr_en;
  logic [ADDR_W-1:0]   r_bus_addr;
  logic [1:0]          r_bus_size;
  logic [31:0]         r_bus_wdata;

  logic                w_misaligned;
  logic [31:0]         w_load_data;

`ifdef EXT_BUS_TIMEOUT_EN
  // Counter is at least 8 bits and wide enough to hold TIMEOUT_CYCLES.
  localparam int WAIT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  logic [WAIT_W-1:0]   r_wait;
`endif

  // Reject illegal sizes and accesses not aligned to their size.
  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_misaligned = 1'b0;
    case (cpu_size)
      SZ_HALF: w_misaligned = cpu_addr[0];
      SZ_WORD: w_misaligned = (cpu_addr[1:0] != 2'b00);
      SZ_ILL:  w_misaligned = 1'b1;
      default: w_misaligned = 1'b0;
    endcase
  end

  // Extend the right-aligned peripheral read data by the latched access size.
  always_comb begin
    w_load_data = bus_rdata;
    case (r_size)
      SZ_BYTE: w_load_data = {{24{~r_unsigned & bus_rdata[7]}},  bus_rdata[7:0]};
      SZ_HALF: w_load_data = {{16{~r_unsigned & bus_rdata[15]}}, bus_rdata[15:0]};
      default: w_load_data = bus_rdata;
    endcase
  end

  // Transaction FSM; every output is a register updated together with the state.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; every register, including the state, is cleared inside the clocked block.
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_unsigned  <= 1'b0;
      r_size      <= 2'b00;
      r_busy      <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_cpu_rdata <= 32'h0;
      r_cpu_err   <= 1'b0;
      r_bus_req   <= 1'b0;
      r_bus_wr_en <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_size  <= 2'b00;
      r_bus_wdata <= 32'h0;
`ifdef EXT_BUS_TIMEOUT_EN
      r_wait      <= '0;
`endif
    end else begin
      r_cpu_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cpu_req) begin
            r_we       <= cpu_we;
            r_size     <= cpu_size;
            r_unsigned <= cpu_unsigned;
            r_busy     <= 1'b1;
            if (w_misaligned) begin
              // Rejected without touching the bus.
              r_state     <= S_RESP;
              r_cpu_ack   <= 1'b1;
              r_cpu_err   <= 1'b1;
              r_cpu_rdata <= 32'h0;
            end else begin
              r_state     <= S_REQ;
              r_bus_req   <= 1'b1;
              r_bus_wr_en <= cpu_we;
              r_bus_addr  <= cpu_addr;
              r_bus_size  <= cpu_size;
              r_bus_wdata <= cpu_wdata;
`ifdef EXT_BUS_TIMEOUT_EN
              r_wait      <= '0;
`endif
            end
          end
        end

        S_REQ, S_DATA: begin
          if (bus_ready) begin
            if (r_state == S_REQ) begin
              // Address accepted: drop the strobe, keep the rest of the bus held.
              r_state   <= S_DATA;
              r_bus_req <= 1'b0;
`ifdef EXT_BUS_TIMEOUT_EN
              r_wait    <= '0;
`endif
            end else begin
              r_state     <= S_RESP;
              r_cpu_ack   <= 1'b1;
              r_cpu_err   <= 1'b0;
              r_cpu_rdata <= r_we ? 32'h0 : w_load_data;
              r_bus_wr_en <= 1'b0;
              r_bus_addr  <= '0;
              r_bus_size  <= 2'b00;
              r_bus_wdata <= 32'h0;
            end
          end
`ifdef EXT_BUS_TIMEOUT_EN
          else if (r_wait == WAIT_LAST) begin
            // Peripheral never answered: abandon the access and report an error.
            r_state     <= S_RESP;
            r_cpu_ack   <= 1'b1;
            r_cpu_err   <= 1'b1;
            r_cpu_rdata <= 32'h0;
            r_bus_req   <= 1'b0;
            r_bus_wr_en <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_size  <= 2'b00;
            r_bus_wdata <= 32'h0;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
`endif
        end

        S_RESP: begin
          // A cpu_req seen here is ignored; it is sampled again in IDLE.
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cpu_busy  = r_busy;
  assign cpu_ack   = r_cpu_ack;
  assign cpu_rdata = r_cpu_rdata;
  assign cpu_err   = r_cpu_err;
  assign bus_req   = r_bus_req;
  assign bus_wr_en = r_bus_wr_en;
  assign bus_addr  = r_bus_addr;
  assign bus_size  = r_bus_size;
  assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_ext_mem_bus_initiator.sv
// Directed testbench for ext_mem_bus_initiator with a byte-addressed
// peripheral memory model. Timeout checks depend on EXT_BUS_TIMEOUT_EN.
module tb_ext_mem_bus_initiator;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, cpu_unsigned;
  logic [15:0] cpu_addr;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_wdata;
  logic        cpu_busy, cpu_ack, cpu_err;
  logic [31:0] cpu_rdata;
  logic        bus_req, bus_wr_en, bus_ready;
  logic [15:0] bus_addr;
  logic [1:0]  bus_size;
  logic [31:0] bus_wdata, bus_rdata;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [7:0] mem [0:511];
  logic [8:0] w_a;

  always #5 clk = ~clk;

  ext_mem_bus_initiator #(.ADDR_W(16), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_size(cpu_size),
    .cpu_unsigned(cpu_unsigned), .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .bus_req(bus_req), .bus_wr_en(bus_wr_en), .bus_addr(bus_addr), .bus_size(bus_size),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready)
  );

  // Peripheral read data: bytes starting at bus_addr, right-aligned.
  always_comb begin
    w_a       = bus_addr[8:0];
    bus_rdata = {mem[w_a + 9'd3], mem[w_a + 9'd2], mem[w_a + 9'd1], mem[w_a]};
  end

  // Peripheral memory: preset bytes during reset, commit writes on an accepted request.
  always @(posedge clk) begin
    if (!rst_n) begin
      mem[9'h010] <= 8'h80;
      mem[9'h011] <= 8'h56;
      mem[9'h012] <= 8'h34;
      mem[9'h013] <= 8'h12;
    end else if (bus_req && bus_ready && bus_wr_en) begin
      mem[w_a] <= bus_wdata[7:0];
      if (bus_size != 2'b00) mem[w_a + 9'd1] <= bus_wdata[15:8];
      if (bus_size == 2'b10) begin
        mem[w_a + 9'd2] <= bus_wdata[23:16];
        mem[w_a + 9'd3] <= bus_wdata[31:24];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One CPU access. Called at a falling edge with the DUT idle. lat counts falling
  // edges after the sampling edge up to the one that sees cpu_ack (1 = ack in the
  // cycle right after sampling). nreq counts cycles with bus_req high.
  task automatic txn(input logic we, input logic [15:0] addr, input logic [1:0] size,
                     input logic uns, input logic [31:0] wdata,
                     input int req_stall, input int data_stall, input logic keep_req,
                     output int lat, output int nreq, output logic [31:0] rd, output logic err);
    int   rs, ds;
    logic acked;
    rs = req_stall; ds = data_stall; lat = 0; nreq = 0; rd = 'x; err = 'x; acked = 1'b0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_size = size;
    cpu_unsigned = uns; cpu_wdata = wdata;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    while (!acked && lat < 60) begin
      @(negedge clk);
      lat++;
      if (cpu_ack) begin
        acked = 1'b1;
        rd    = cpu_rdata;
        err   = cpu_err;
      end else if (bus_req) begin
        nreq++;
        bus_ready = (rs == 0);
        if (rs > 0) rs--;
      end else if (cpu_busy) begin
        check("data_hold_addr",  32'(bus_addr),  32'(addr));
        check("data_hold_wdata", bus_wdata,      wdata);
        check("data_hold_wr_en", 32'(bus_wr_en), 32'(we));
        check("data_hold_size",  32'(bus_size),  32'(size));
        bus_ready = (ds == 0);
        if (ds > 0) ds--;
      end
    end
    check("ack_seen", 32'(acked), 32'd1);
    check("resp_busy", 32'(cpu_busy), 32'd1);
    check("resp_bus_idle", {bus_req, bus_wr_en, bus_size, 12'h0, bus_addr}, 32'h0);
    bus_ready = 1'b1;
    if (keep_req) cpu_req = 1'b1;
    @(negedge clk);
    check("ack_one_cycle", 32'(cpu_ack), 32'd0);
    check("idle_after_resp", 32'(cpu_busy), 32'd0);
  endtask

  int          lat, nreq, n_ack;
  logic [31:0] rd;
  logic        err;

  initial begin
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_size = 2'b00;
    cpu_unsigned = 1'b0; cpu_wdata = '0; bus_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",  32'(cpu_busy),  32'd0);
    check("rst_ack",   32'(cpu_ack),   32'd0);
    check("rst_rdata", cpu_rdata,      32'h0);
    check("rst_err",   32'(cpu_err),   32'd0);
    check("rst_bus",   {bus_req, bus_wr_en, bus_size, 12'h0, bus_addr}, 32'h0);
    check("rst_wdata", bus_wdata,      32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Signed byte load: ack three cycles after the request.
    txn(1'b0, 16'h0010, 2'b00, 1'b0, 32'h0, 0, 0, 1'b0, lat, nreq, rd, err);
    check("lb_lat", 32'(lat), 32'd3);
    check("lb_nreq", 32'(nreq), 32'd1);
    check("lb_rdata", rd, 32'hFFFF_FF80);
    check("lb_err", 32'(err), 32'd0);

    txn(1'b0, 16'h0010, 2'b00, 1'b1, 32'h0, 0, 0, 1'b0, lat, nreq, rd, err);
    check("lbu_rdata", rd, 32'h0000_0080);

    // Halfword load; cpu_req is held through RESP and must not start a new access there.
    txn(1'b0, 16'h0010, 2'b01, 1'b1, 32'h0, 0, 0, 1'b1, lat, nreq, rd, err);
    check("lhu_rdata", rd, 32'h0000_5680);

    txn(1'b0, 16'h0010, 2'b10, 1'b0, 32'h0, 0, 0, 1'b0, lat, nreq, rd, err);
    check("lw_lat", 32'(lat), 32'd3);
    check("lw_rdata", rd, 32'h1234_5680);

    txn(1'b0, 16'h0012, 2'b01, 1'b0, 32'h0, 0, 0, 1'b0, lat, nreq, rd, err);
    check("lh_pos_rdata", rd, 32'h0000_1234);

    // Word store with 4 stall cycles in DATA: 3 + 4 = 7.
    txn(1'b1, 16'h0100, 2'b10, 1'b0, 32'hDEAD_BEEF, 0, 4, 1'b0, lat, nreq, rd, err);
    check("sw_lat", 32'(lat), 32'd7);
    check("sw_nreq", 32'(nreq), 32'd1);
    check("sw_rdata", rd, 32'h0);
    check("sw_err", 32'(err), 32'd0);

    txn(1'b0, 16'h0100, 2'b10, 1'b0, 32'h0, 0, 0, 1'b0, lat, nreq, rd, err);
    check("lw_back_rdata", rd, 32'hDEAD_BEEF);

    // Halfword store of a negative value, read back signed and unsigned.
    txn(1'b1, 16'h0104, 2'b01, 1'b0, 32'h0000_8001, 0, 0, 1'b0, lat, nreq, rd, err);
    txn(1'b0, 16'h0104, 2'b01, 1'b0, 32'h0, 0, 0, 1'b0, lat, nreq, rd, err);
    check("lh_neg_rdata", rd, 32'hFFFF_8001);
    txn(1'b0, 16'h0104, 2'b01, 1'b1, 32'h0, 0, 0, 1'b0, lat, nreq, rd, err);
    check("lhu_neg_rdata", rd, 32'h0000_8001);

    // Two stall cycles in REQ: strobe held 3 cycles, ack at 3 + 2.
    txn(1'b0, 16'h0010, 2'b10, 1'b0, 32'h0, 2, 0, 1'b0, lat, nreq, rd, err);
    check("req_stall_lat", 32'(lat), 32'd5);
    check("req_stall_nreq", 32'(nreq), 32'd3);
    check("req_stall_rdata", rd, 32'h1234_5680);

    // Misaligned and illegal requests: no bus activity, error ack next cycle.
    txn(1'b0, 16'h0102, 2'b10, 1'b0, 32'h0, 0, 0, 1'b0, lat, nreq, rd, err);
    check("mis_w_lat", 32'(lat), 32'd1);
    check("mis_w_nreq", 32'(nreq), 32'd0);
    check("mis_w_err", 32'(err), 32'd1);
    txn(1'b0, 16'h0000, 2'b11, 1'b0, 32'h0, 0, 0, 1'b0, lat, nreq, rd, err);
    check("ill_lat", 32'(lat), 32'd1);
    check("ill_nreq", 32'(nreq), 32'd0);
    check("ill_err", 32'(err), 32'd1);
    txn(1'b1, 16'h0011, 2'b01, 1'b0, 32'h0000_FFFF, 0, 0, 1'b0, lat, nreq, rd, err);
    check("mis_h_err", 32'(err), 32'd1);
    check("mis_h_nreq", 32'(nreq), 32'd0);
    txn(1'b0, 16'h0013, 2'b00, 1'b0, 32'h0, 0, 0, 1'b0, lat, nreq, rd, err);
    check("lb_odd_err", 32'(err), 32'd0);
    check("lb_odd_rdata", rd, 32'h0000_0012);

    // Reset while in DATA: everything clears, no ack follows.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010; cpu_size = 2'b00;
    cpu_unsigned = 1'b0; cpu_wdata = '0; bus_ready = 1'b1;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    @(negedge clk);
    check("mid_rst_req_phase", 32'(bus_req), 32'd1);
    @(negedge clk);
    check("mid_rst_data_phase", {cpu_busy, bus_req}, 32'b10);
    bus_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 32'(cpu_busy), 32'd0);
    check("mid_rst_ack", 32'(cpu_ack), 32'd0);
    check("mid_rst_rdata", cpu_rdata, 32'h0);
    check("mid_rst_bus", {bus_req, bus_wr_en, bus_size, 12'h0, bus_addr}, 32'h0);
    rst_n = 1'b1; bus_ready = 1'b1;
    n_ack = 0;
    repeat (3) begin
      @(negedge clk);
      if (cpu_ack) n_ack++;
    end
    check("mid_rst_no_ack", 32'(n_ack), 32'd0);
    txn(1'b0, 16'h0010, 2'b00, 1'b0, 32'h0, 0, 0, 1'b0, lat, nreq, rd, err);
    check("post_rst_lb_rdata", rd, 32'hFFFF_FF80);
    check("post_rst_lb_lat", 32'(lat), 32'd3);

`ifdef EXT_BUS_TIMEOUT_EN
    // Peripheral never ready: abort lands TO cycles after REQ entry (lat counts from 1).
    txn(1'b0, 16'h0010, 2'b10, 1'b0, 32'h0, 1000, 0, 1'b0, lat, nreq, rd, err);
    check("to_lat", 32'(lat), 32'(TO + 1));
    check("to_nreq", 32'(nreq), 32'(TO));
    check("to_err", 32'(err), 32'd1);
    check("to_rdata", rd, 32'h0);
`else
    // Without the timeout the initiator waits forever.
    bus_ready = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010; cpu_size = 2'b10; cpu_unsigned = 1'b0;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    n_ack = 0;
    repeat (1000) begin
      @(negedge clk);
      if (cpu_ack) n_ack++;
    end
    check("no_to_ack", 32'(n_ack), 32'd0);
    check("no_to_busy", 32'(cpu_busy), 32'd1);
    check("no_to_req", 32'(bus_req), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; bus_ready = 1'b1;
    @(negedge clk);
`endif

    txn(1'b0, 16'h0010, 2'b10, 1'b0, 32'h0, 0, 0, 1'b0, lat, nreq, rd, err);
    check("final_lw_rdata", rd, 32'h1234_5680);
    check("final_lw_err", 32'(err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
